ros2_ip_tx_unpacker: RTL and testbench

Transmit-direction counterpart of the Ethernet RX adapter. It pops the serialized IP frame byte stream that ros2rapper writes into the external TX FIFO and splits it into an IP header handshake plus an AXI-Stream payload for the verilog_ethernet IP transmit port. Frames that are empty or oversize are consumed and discarded without reaching the MAC.

---
 rtl/ros2_ip_tx_unpacker_pkg.sv | 20 ++
 rtl/ros2_ip_tx_unpacker.sv | 169 ++++++++++++++++
 tb/tb_ros2_ip_tx_unpacker.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ros2_ip_tx_unpacker_pkg.sv
// Shared constants and types for the ROS2 IP transmit unpacker.
//   StreamHdrLen      : bytes of stream header preceding each payload (dest, src, proto, len)
//   Ipv4HdrLen        : IPv4 header bytes added to the payload length for tx_ip_length
//   MaxPayloadDefault : default upper bound on accepted payload length
//   state_e           : unpacker FSM states
package ros2_ip_tx_unpacker_pkg;

    localparam int unsigned StreamHdrLen      = 11;
    localparam int unsigned Ipv4HdrLen        = 20;
    localparam int unsigned MaxPayloadDefault = 1472;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StHdrOut,
        StPayload,
        StDiscard
    } state_e;

endpackage

// File: rtl/ros2_ip_tx_unpacker.sv
// Pops a serialized IP frame stream from a first-word-fall-through FIFO and splits it
// into an IP header handshake plus an AXI-Stream payload. Frames with an empty or
// oversize payload are consumed and dropped.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   enable                : gates the start of new frames only
//   fifo_dout/fifo_empty  : FIFO head byte and empty flag; fifo_rd_en pops one byte
//   tx_ip_hdr_*           : registered IP header fields with valid/ready handshake
//   tx_payload_*          : payload stream, combinational pass-through of the FIFO head
//   drop_pulse            : one-cycle pulse after a discarded frame is fully consumed
module ros2_ip_tx_unpacker
    import ros2_ip_tx_unpacker_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = MaxPayloadDefault,
    parameter logic [7:0]  DEFAULT_TTL = 8'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        tx_ip_hdr_valid,
    input  logic        tx_ip_hdr_ready,
    output logic [31:0] tx_ip_dest_ip,
    output logic [31:0] tx_ip_source_ip,
    output logic [7:0]  tx_ip_protocol,
    output logic [15:0] tx_ip_length,
    output logic [7:0]  tx_ip_ttl,
    output logic [5:0]  tx_ip_dscp,
    output logic [1:0]  tx_ip_ecn,
    output logic [7:0]  tx_payload_tdata,
    output logic        tx_payload_tvalid,
    input  logic        tx_payload_tready,
    output logic        tx_payload_tlast,
    output logic        drop_pulse
);

    localparam logic [3:0] LastHdrIdx = 4'(StreamHdrLen - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] dest_q, dest_d;
    logic [31:0] src_q, src_d;
    logic [7:0]  proto_q, proto_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] length_q, length_d;
    logic [15:0] rem_q, rem_d;

    logic [15:0] len_word;
    logic        len_bad;

    // Payload length as it completes on the last header byte.
    assign len_word = {len_hi_q, fifo_dout};
    assign len_bad  = (len_word == 16'd0) || ({16'd0, len_word} > MAX_PAYLOAD);

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        dest_d            = dest_q;
        src_d             = src_q;
        proto_d           = proto_q;
        len_hi_d          = len_hi_q;
        length_d          = length_q;
        rem_d             = rem_q;
        fifo_rd_en        = 1'b0;
        tx_ip_hdr_valid   = 1'b0;
        tx_payload_tvalid = 1'b0;
        tx_payload_tlast  = 1'b0;
        drop_pulse        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable && !fifo_empty) begin
                    state_d = StHdr;
                end
            end

            StHdr: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    idx_d      = idx_q + 4'd1;
                    if (idx_q < 4'd4) begin
                        dest_d = {dest_q[23:0], fifo_dout};
                    end else if (idx_q < 4'd8) begin
                        src_d = {src_q[23:0], fifo_dout};
                    end else if (idx_q == 4'd8) begin
                        proto_d = fifo_dout;
                    end else if (idx_q == 4'd9) begin
                        len_hi_d = fifo_dout;
                    end else if (idx_q == LastHdrIdx) begin
                        idx_d = 4'd0;
                        rem_d = len_word;
                        if (len_bad) begin
                            state_d = StDiscard;
                        end else begin
                            length_d = len_word + 16'(Ipv4HdrLen);
                            state_d  = StHdrOut;
                        end
                    end
                end
            end

            StHdrOut: begin
                tx_ip_hdr_valid = 1'b1;
                if (tx_ip_hdr_ready) begin
                    state_d = StPayload;
                end
            end

            StPayload: begin
                tx_payload_tvalid = !fifo_empty;
                tx_payload_tlast  = (rem_q == 16'd1);
                fifo_rd_en        = tx_payload_tvalid && tx_payload_tready;
                if (fifo_rd_en) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = StIdle;
                    end
                end
            end

            StDiscard: begin
                if (rem_q == 16'd0) begin
                    drop_pulse = 1'b1;
                    state_d    = StIdle;
                end else if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    rem_d      = rem_q - 16'd1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            dest_q   <= 32'd0;
            src_q    <= 32'd0;
            proto_q  <= 8'd0;
            len_hi_q <= 8'd0;
            length_q <= 16'd0;
            rem_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dest_q   <= dest_d;
            src_q    <= src_d;
            proto_q  <= proto_d;
            len_hi_q <= len_hi_d;
            length_q <= length_d;
            rem_q    <= rem_d;
        end
    end

    assign tx_ip_dest_ip    = dest_q;
    assign tx_ip_source_ip  = src_q;
    assign tx_ip_protocol   = proto_q;
    assign tx_ip_length     = length_q;
    assign tx_ip_ttl        = DEFAULT_TTL;
    assign tx_ip_dscp       = 6'd0;
    assign tx_ip_ecn        = 2'd0;
    // Gated so the stream data reads zero outside a payload phase.
    assign tx_payload_tdata = (state_q == StPayload) ? fifo_dout : 8'd0;

endmodule

// File: tb/tb_ros2_ip_tx_unpacker.sv
module tb_ros2_ip_tx_unpacker;

    localparam int unsigned MaxPay = 1472;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  fifo_dout = 8'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic        tx_ip_hdr_valid;
    logic        tx_ip_hdr_ready;
    logic [31:0] tx_ip_dest_ip;
    logic [31:0] tx_ip_source_ip;
    logic [7:0]  tx_ip_protocol;
    logic [15:0] tx_ip_length;
    logic [7:0]  tx_ip_ttl;
    logic [5:0]  tx_ip_dscp;
    logic [1:0]  tx_ip_ecn;
    logic [7:0]  tx_payload_tdata;
    logic        tx_payload_tvalid;
    logic        tx_payload_tready;
    logic        tx_payload_tlast;
    logic        drop_pulse;

    ros2_ip_tx_unpacker #(
        .MAX_PAYLOAD (MaxPay),
        .DEFAULT_TTL (8'd64)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .fifo_dout         (fifo_dout),
        .fifo_empty        (fifo_empty),
        .fifo_rd_en        (fifo_rd_en),
        .tx_ip_hdr_valid   (tx_ip_hdr_valid),
        .tx_ip_hdr_ready   (tx_ip_hdr_ready),
        .tx_ip_dest_ip     (tx_ip_dest_ip),
        .tx_ip_source_ip   (tx_ip_source_ip),
        .tx_ip_protocol    (tx_ip_protocol),
        .tx_ip_length      (tx_ip_length),
        .tx_ip_ttl         (tx_ip_ttl),
        .tx_ip_dscp        (tx_ip_dscp),
        .tx_ip_ecn         (tx_ip_ecn),
        .tx_payload_tdata  (tx_payload_tdata),
        .tx_payload_tvalid (tx_payload_tvalid),
        .tx_payload_tready (tx_payload_tready),
        .tx_payload_tlast  (tx_payload_tlast),
        .drop_pulse        (drop_pulse)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model; gap forces empty cycles after every pop.
    logic [7:0] fifo_q[$];
    int         gap = 0;
    int         gap_cnt = 0;

    always @(posedge clk) begin
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_q.delete(0);
            gap_cnt = gap;
        end else if (gap_cnt > 0) begin
            gap_cnt = gap_cnt - 1;
        end
        fifo_empty <= (fifo_q.size() == 0) || (gap_cnt > 0);
        fifo_dout  <= (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end

    // Expected transactions derived from the frames pushed.
    typedef struct packed {
        logic [31:0] dest;
        logic [31:0] src;
        logic [7:0]  proto;
        logic [15:0] len;
        logic [7:0]  ttl;
        logic [5:0]  dscp;
        logic [1:0]  ecn;
    } hdr_t;

    hdr_t       exp_hdr_q[$];
    logic [8:0] exp_pay_q[$];
    int         exp_drops = 0;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_rd = 0;
    int hdr_seen = 0;
    int pay_seen = 0;
    int drops_seen = 0;
    logic [15:0] last_len = 16'd0;
    int hold = 0;
    int hold_cnt = 0;
    int trmode = 0;
    logic prev_hv = 1'b0;
    logic prev_hr = 1'b0;
    hdr_t prev_hdr;
    int t0, t_rd, t_hv, t_drop, t_last, t_rd2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_frame(input logic [31:0] dest, input logic [31:0] src,
                              input logic [7:0] proto, input logic [15:0] len,
                              input bit fixed, input logic [31:0] fixed_data);
        logic [7:0] b;
        bit good;
        good = (len != 16'd0) && (len <= 16'(MaxPay));
        for (int i = 0; i < 4; i++) fifo_q.push_back(dest[31 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) fifo_q.push_back(src[31 - 8*i -: 8]);
        fifo_q.push_back(proto);
        fifo_q.push_back(len[15:8]);
        fifo_q.push_back(len[7:0]);
        for (int i = 0; i < int'(len); i++) begin
            b = (fixed && i < 4) ? fixed_data[31 - 8*i -: 8] : 8'($urandom);
            fifo_q.push_back(b);
            if (good) exp_pay_q.push_back({(i == int'(len) - 1), b});
        end
        if (good) exp_hdr_q.push_back({dest, src, proto, len + 16'd20, 8'd64, 6'd0, 2'd0});
        else exp_drops++;
    endtask

    task automatic mon();
        hdr_t cur;
        hdr_t e;
        logic [8:0] ep;
        cur = {tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol, tx_ip_length,
               tx_ip_ttl, tx_ip_dscp, tx_ip_ecn};
        if (prev_hv && !prev_hr) begin
            chk("hdr_valid_hold", 128'(tx_ip_hdr_valid), 128'd1);
            chk("hdr_fields_stable", 128'(cur), 128'(prev_hdr));
        end
        if (tx_ip_hdr_valid && tx_ip_hdr_ready) begin
            chk("hdr_pending", 128'(exp_hdr_q.size() > 0), 128'd1);
            if (exp_hdr_q.size() > 0) begin
                e = exp_hdr_q.pop_front();
                chk("hdr_fields", 128'(cur), 128'(e));
            end
            last_len = tx_ip_length;
            hdr_seen++;
        end
        if (fifo_rd_en) begin
            chk("rd_en_while_empty", 128'(fifo_empty), 128'd0);
            n_rd++;
            if (t_rd < 0) t_rd = cyc;
        end
        if (tx_payload_tvalid) begin
            chk("tvalid_vs_empty", 128'(fifo_empty), 128'd0);
            chk("tdata_passthru", 128'(tx_payload_tdata), 128'(fifo_dout));
            chk("rd_en_eq_xfer", 128'(fifo_rd_en), 128'(tx_payload_tready));
        end
        if (tx_payload_tvalid && tx_payload_tready) begin
            chk("pay_pending", 128'(exp_pay_q.size() > 0), 128'd1);
            if (exp_pay_q.size() > 0) begin
                ep = exp_pay_q.pop_front();
                chk("pay_byte_last", 128'({tx_payload_tlast, tx_payload_tdata}), 128'(ep));
            end
            pay_seen++;
            if (tx_payload_tlast && t_last < 0) t_last = cyc;
        end
        if (fifo_rd_en && t_last >= 0 && t_rd2 < 0 && cyc > t_last) t_rd2 = cyc;
        if (tx_ip_hdr_valid && t_hv < 0) t_hv = cyc;
        if (drop_pulse) begin
            chk("drop_expected", 128'(exp_drops > 0), 128'd1);
            if (exp_drops > 0) exp_drops--;
            drops_seen++;
            if (t_drop < 0) t_drop = cyc;
        end
        prev_hv  = tx_ip_hdr_valid;
        prev_hr  = tx_ip_hdr_ready;
        prev_hdr = cur;
        cyc++;
    endtask

    task automatic drive();
        tx_ip_hdr_ready = tx_ip_hdr_valid && (hold_cnt >= hold);
        case (trmode)
            0: tx_payload_tready = 1'b1;
            1: tx_payload_tready = ~tx_payload_tready;
            default: tx_payload_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Entered and left at posedge+1; outputs are sampled mid-cycle.
    task automatic step();
        drive();
        #2;
        mon();
        if (tx_ip_hdr_valid) hold_cnt = tx_ip_hdr_ready ? 0 : hold_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic mark();
        t0 = cyc; t_rd = -1; t_hv = -1; t_drop = -1; t_last = -1; t_rd2 = -1;
    endtask

    task automatic run_until_done(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            step();
            done = (fifo_q.size() == 0) && (exp_hdr_q.size() == 0) &&
                   (exp_pay_q.size() == 0) && (exp_drops == 0);
        end
        chk({name, "_done"}, 128'(done), 128'd1);
        step();
    endtask

    typedef struct {
        logic [31:0] dest;
        logic [31:0] src;
        logic [7:0]  proto;
        logic [15:0] len;
        int          gap;
        int          hold;
        int          tr;
        logic [15:0] exp_len;
        int          exp_drop;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, h0, base, rd0;

        vecs[0]  = '{32'h0A000001, 32'h0A000002, 8'h06, 16'd1,    0, 0, 0, 16'd21,   0};
        vecs[1]  = '{32'hC0A80102, 32'hC0A80101, 8'h11, 16'd4,    0, 5, 1, 16'd24,   0};
        vecs[2]  = '{32'h01020304, 32'h05060708, 8'h11, 16'd10,   3, 0, 0, 16'd30,   0};
        vecs[3]  = '{32'hC0A80102, 32'hC0A80101, 8'h11, 16'd4,    3, 2, 2, 16'd24,   0};
        vecs[4]  = '{32'hAC100001, 32'hAC100002, 8'h11, 16'd1472, 0, 0, 0, 16'd1492, 0};
        vecs[5]  = '{32'h11111111, 32'h22222222, 8'h11, 16'd1473, 0, 0, 0, 16'd0,    1};
        vecs[6]  = '{32'h33333333, 32'h44444444, 8'h11, 16'd2,    0, 0, 0, 16'd22,   0};
        vecs[7]  = '{32'h55555555, 32'h66666666, 8'h11, 16'd0,    0, 0, 0, 16'd0,    1};
        vecs[8]  = '{32'h77777777, 32'h88888888, 8'h11, 16'd16,   1, 0, 2, 16'd36,   0};
        vecs[9]  = '{32'h99999999, 32'hAAAAAAAA, 8'h11, 16'd2000, 0, 0, 0, 16'd0,    1};
        vecs[10] = '{32'h0A0A0A0A, 32'h0B0B0B0B, 8'h01, 16'd33,   1, 1, 2, 16'd53,   0};

        rst_n = 1'b0;
        enable = 1'b0;
        tx_ip_hdr_ready = 1'b0;
        tx_payload_tready = 1'b0;
        mark();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 128'({tx_ip_hdr_valid, fifo_rd_en, tx_payload_tvalid,
                             tx_payload_tlast, drop_pulse}), 128'd0);
        chk("rst_fields", 128'({tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol,
                               tx_ip_length, tx_ip_dscp, tx_ip_ecn, tx_payload_tdata}), 128'd0);
        chk("rst_ttl", 128'(tx_ip_ttl), 128'd64);
        rst_n = 1'b1;
        step();

        // Normal frame preloaded, then a back-to-back second frame
        push_frame(32'hC0A80102, 32'hC0A80101, 8'h11, 16'd4, 1'b1, 32'hDEADBEEF);
        push_frame(32'h0A000001, 32'h0A000009, 8'h06, 16'd2, 1'b0, 32'd0);
        rd0 = n_rd;
        repeat (3) step();
        chk("idle_no_pop_when_disabled", 128'(n_rd - rd0), 128'd0);
        mark();
        enable = 1'b1;
        run_until_done("normal", 200);
        chk("first_pop_latency", 128'(t_rd - t0), 128'd1);
        chk("hdr_valid_latency", 128'(t_hv - t0), 128'd12);
        chk("idle_gap", 128'(t_rd2 - t_last), 128'd2);
        chk("second_len", 128'(last_len), 128'd22);

        // Table of frames: inputs plus expected length / drop outcome
        for (int v = 0; v < 11; v++) begin
            gap = vecs[v].gap;
            hold = vecs[v].hold;
            trmode = vecs[v].tr;
            d0 = drops_seen;
            h0 = hdr_seen;
            push_frame(vecs[v].dest, vecs[v].src, vecs[v].proto, vecs[v].len, 1'b0, 32'd0);
            run_until_done("vec", 10000);
            chk("vec_drop_count", 128'(drops_seen - d0), 128'(vecs[v].exp_drop));
            chk("vec_hdr_count", 128'(hdr_seen - h0), 128'(1 - vecs[v].exp_drop));
            if (vecs[v].exp_drop == 0) chk("vec_ip_length", 128'(last_len), 128'(vecs[v].exp_len));
        end
        gap = 0;
        hold = 0;
        trmode = 0;

        // L=0 drops on the cycle after the header completes
        enable = 1'b0;
        push_frame(32'h01010101, 32'h02020202, 8'h11, 16'd0, 1'b0, 32'd0);
        repeat (3) step();
        mark();
        enable = 1'b1;
        run_until_done("zero_len", 100);
        chk("zero_len_drop_time", 128'(t_drop - t0), 128'd12);

        // Enable dropped mid-payload: frame completes, next one waits
        base = pay_seen;
        push_frame(32'hC0A80102, 32'hC0A80101, 8'h11, 16'd4, 1'b0, 32'd0);
        for (int c = 0; c < 200 && pay_seen < base + 2; c++) step();
        enable = 1'b0;
        push_frame(32'hC0A80103, 32'hC0A80101, 8'h11, 16'd3, 1'b0, 32'd0);
        for (int c = 0; c < 200 && pay_seen < base + 4; c++) step();
        chk("en_frame_completes", 128'(pay_seen - base), 128'd4);
        rd0 = n_rd;
        h0 = hdr_seen;
        repeat (20) step();
        chk("en_next_not_started", 128'(n_rd - rd0), 128'd0);
        chk("en_no_hdr", 128'(hdr_seen - h0), 128'd0);
        enable = 1'b1;
        run_until_done("en_resume", 200);
        chk("en_resume_len", 128'(last_len), 128'd23);

        // Asynchronous reset in the middle of a payload
        base = pay_seen;
        push_frame(32'h0A000001, 32'h0A000002, 8'h11, 16'd8, 1'b0, 32'd0);
        for (int c = 0; c < 200 && pay_seen < base + 3; c++) step();
        chk("arst_in_payload", 128'(tx_payload_tvalid), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 128'({tx_ip_hdr_valid, fifo_rd_en, tx_payload_tvalid,
                              tx_payload_tlast, drop_pulse}), 128'd0);
        chk("arst_fields", 128'({tx_ip_dest_ip, tx_ip_source_ip, tx_ip_protocol,
                                tx_ip_length, tx_payload_tdata}), 128'd0);
        chk("arst_ttl", 128'(tx_ip_ttl), 128'd64);
        @(posedge clk);
        #1;
        rd0 = n_rd;
        repeat (4) step();
        chk("arst_no_pops", 128'(n_rd - rd0), 128'd0);
        fifo_q.delete();
        exp_hdr_q.delete();
        exp_pay_q.delete();
        exp_drops = 0;
        prev_hv = 1'b0;
        hold_cnt = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        push_frame(32'hC0A80105, 32'hC0A80106, 8'h11, 16'd5, 1'b0, 32'd0);
        run_until_done("post_reset", 200);
        chk("post_reset_len", 128'(last_len), 128'd25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
